// File: rtl/riscv_pipe_pkg.sv
// Shared encodings, instruction classes and bypass-select type for the 5-stage pipe.
package riscv_pipe_pkg;

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_REG    = 7'b0110011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    localparam logic [2:0]  F3_ADDI   = 3'b000;
    localparam logic [2:0]  F3_BEQ    = 3'b000;
    localparam logic [2:0]  F3_LW     = 3'b010;
    localparam logic [2:0]  F3_LD     = 3'b011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_LD,
        CLS_SD,
        CLS_ADDI,
        CLS_ADD,
        CLS_BEQ
    } instr_cls_e;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_MEM,
        FWD_WB
    } fwd_sel_e;

    // Classify an instruction; anything unrecognised collapses to NOP.
    function automatic instr_cls_e decode_cls(input logic [6:0] opcode,
                                              input logic [2:0] funct3,
                                              input logic [6:0] funct7,
                                              input logic [2:0] mem_f3);
        instr_cls_e cls;
        cls = CLS_NOP;
        case (opcode)
            OP_LOAD:   if (funct3 == mem_f3)  cls = CLS_LD;
            OP_STORE:  if (funct3 == mem_f3)  cls = CLS_SD;
            OP_IMM:    if (funct3 == F3_ADDI) cls = CLS_ADDI;
            OP_REG:    if (funct7 == 7'b0)    cls = CLS_ADD;
            OP_BRANCH: if (funct3 == F3_BEQ)  cls = CLS_BEQ;
            default:   cls = CLS_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/riscv_hazard_unit.sv
// Interlock and bypass-select logic for the 5-stage pipe (purely combinational).
module riscv_hazard_unit
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned FWD_EN = 1
) (
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    input  logic [4:0] ex_rs1_i,
    input  logic [4:0] ex_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_is_ld_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_is_ld_i,
    input  logic [4:0] wb_rd_i,
    output logic       stall_c_o,
    output fwd_sel_e   fwd_a_c_o,
    output fwd_sel_e   fwd_b_c_o
);

    // A producer matters only if it writes a real register that is actually read.
    function automatic logic hit(input logic [4:0] rd, input logic [4:0] rs, input logic use_rs);
        return use_rs && (rd != 5'd0) && (rd == rs);
    endfunction

    // Stall decision and bypass source selection; EX/MEM beats MEM/WB.
    always_comb begin
        stall_c_o = 1'b0;
        fwd_a_c_o = FWD_RF;
        fwd_b_c_o = FWD_RF;
        if (FWD_EN != 0) begin
            stall_c_o = ex_is_ld_i &&
                        (hit(ex_rd_i, id_rs1_i, id_use_rs1_i) || hit(ex_rd_i, id_rs2_i, id_use_rs2_i));
            if (hit(wb_rd_i, ex_rs1_i, 1'b1))                  fwd_a_c_o = FWD_WB;
            if (!mem_is_ld_i && hit(mem_rd_i, ex_rs1_i, 1'b1)) fwd_a_c_o = FWD_MEM;
            if (hit(wb_rd_i, ex_rs2_i, 1'b1))                  fwd_b_c_o = FWD_WB;
            if (!mem_is_ld_i && hit(mem_rd_i, ex_rs2_i, 1'b1)) fwd_b_c_o = FWD_MEM;
        end else begin
            stall_c_o = hit(ex_rd_i,  id_rs1_i, id_use_rs1_i) || hit(ex_rd_i,  id_rs2_i, id_use_rs2_i) ||
                        hit(mem_rd_i, id_rs1_i, id_use_rs1_i) || hit(mem_rd_i, id_rs2_i, id_use_rs2_i) ||
                        hit(wb_rd_i,  id_rs1_i, id_use_rs1_i) || hit(wb_rd_i,  id_rs2_i, id_use_rs2_i);
        end
    end

endmodule

// File: rtl/riscv_pipe_param.sv
// Parameterised 5-stage in-order pipe: LD/SD/ADDI/ADD/BEQ, static not-taken, optional bypassing.
module riscv_pipe_param
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned FWD_EN  = 1,
    parameter int unsigned IADDR_W = 10,
    parameter int unsigned DADDR_W = 10
) (
    input  logic               clock,
    input  logic               reset,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic               dmem_we,
    output logic [XLEN-1:0]    dmem_wdata,
    input  logic [XLEN-1:0]    dmem_rdata,
    output logic               retire_valid,
    output logic [4:0]         retire_rd,
    output logic [XLEN-1:0]    retire_data,
    output logic               stall,
    output logic               flush
);

    localparam int unsigned PC_W    = IADDR_W + 2;
    localparam int unsigned BYTE_SH = (XLEN == 64) ? 3 : 2;
    localparam logic [2:0]  MEM_F3  = (XLEN == 64) ? F3_LD : F3_LW;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     ifid_instr_q, ifid_instr_d;
    logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
    logic            ifid_valid_q, ifid_valid_d;

    instr_cls_e      idex_cls_q, idex_cls_d;
    logic [4:0]      idex_rd_q, idex_rd_d, idex_rs1_q, idex_rs1_d, idex_rs2_q, idex_rs2_d;
    logic [XLEN-1:0] idex_rs1v_q, idex_rs1v_d, idex_rs2v_q, idex_rs2v_d, idex_imm_q, idex_imm_d;
    logic [PC_W-1:0] idex_pc_q, idex_pc_d;
    logic            idex_valid_q, idex_valid_d;

    instr_cls_e      exmem_cls_q, exmem_cls_d;
    logic [4:0]      exmem_rd_q, exmem_rd_d;
    logic [XLEN-1:0] exmem_alu_q, exmem_alu_d, exmem_sdata_q, exmem_sdata_d;
    logic            exmem_valid_q, exmem_valid_d;

    logic [4:0]      memwb_rd_q, memwb_rd_d;
    logic [XLEN-1:0] memwb_data_q, memwb_data_d;
    logic            memwb_valid_q, memwb_valid_d;

    logic [XLEN-1:0] regs_q [32];

    instr_cls_e      id_cls;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            id_use_rs1, id_use_rs2;
    logic [XLEN-1:0] id_imm, id_rs1v, id_rs2v;
    logic [XLEN-1:0] ex_opa, ex_opb, ex_alu, mem_result;
    logic            ex_taken, hz_stall;
    fwd_sel_e        fwd_a, fwd_b;
    logic            unused_bits;

    // Decode fields of the instruction held in IF/ID.
    always_comb begin
        id_cls     = decode_cls(ifid_instr_q[6:0], ifid_instr_q[14:12], ifid_instr_q[31:25], MEM_F3);
        id_rs1     = ifid_instr_q[19:15];
        id_rs2     = ifid_instr_q[24:20];
        id_rd      = 5'd0;
        id_use_rs1 = (id_cls != CLS_NOP);
        id_use_rs2 = (id_cls == CLS_ADD) || (id_cls == CLS_SD) || (id_cls == CLS_BEQ);
        id_imm     = XLEN'($signed(ifid_instr_q[31:20]));
        case (id_cls)
            CLS_LD, CLS_ADDI, CLS_ADD: id_rd = ifid_instr_q[11:7];
            default: id_rd = 5'd0;
        endcase
        case (id_cls)
            CLS_SD:  id_imm = XLEN'($signed({ifid_instr_q[31:25], ifid_instr_q[11:7]}));
            CLS_BEQ: id_imm = XLEN'($signed({ifid_instr_q[31], ifid_instr_q[7], ifid_instr_q[30:25],
                                              ifid_instr_q[11:8], 1'b0}));
            default: id_imm = XLEN'($signed(ifid_instr_q[31:20]));
        endcase
    end

    // Register read with x0 forced to zero and write-through of the retiring result.
    always_comb begin
        id_rs1v = regs_q[id_rs1];
        id_rs2v = regs_q[id_rs2];
        if (id_rs1 == 5'd0)               id_rs1v = '0;
        else if (memwb_rd_q == id_rs1)    id_rs1v = memwb_data_q;
        if (id_rs2 == 5'd0)               id_rs2v = '0;
        else if (memwb_rd_q == id_rs2)    id_rs2v = memwb_data_q;
    end

    riscv_hazard_unit #(.FWD_EN(FWD_EN)) u_hazard (
        .id_rs1_i     (id_rs1),
        .id_rs2_i     (id_rs2),
        .id_use_rs1_i (id_use_rs1),
        .id_use_rs2_i (id_use_rs2),
        .ex_rs1_i     (idex_rs1_q),
        .ex_rs2_i     (idex_rs2_q),
        .ex_rd_i      (idex_rd_q),
        .ex_is_ld_i   (idex_cls_q == CLS_LD),
        .mem_rd_i     (exmem_rd_q),
        .mem_is_ld_i  (exmem_cls_q == CLS_LD),
        .wb_rd_i      (memwb_rd_q),
        .stall_c_o    (hz_stall),
        .fwd_a_c_o    (fwd_a),
        .fwd_b_c_o    (fwd_b)
    );

    // Execute: operand muxing, adder and branch compare.
    always_comb begin
        ex_opa = idex_rs1v_q;
        ex_opb = idex_rs2v_q;
        if (fwd_a == FWD_MEM)     ex_opa = exmem_alu_q;
        else if (fwd_a == FWD_WB) ex_opa = memwb_data_q;
        if (fwd_b == FWD_MEM)     ex_opb = exmem_alu_q;
        else if (fwd_b == FWD_WB) ex_opb = memwb_data_q;
        ex_alu   = (idex_cls_q == CLS_ADD) ? ex_opa + ex_opb : ex_opa + idex_imm_q;
        ex_taken = (idex_cls_q == CLS_BEQ) && (ex_opa == ex_opb);
        mem_result = (exmem_cls_q == CLS_LD) ? dmem_rdata : exmem_alu_q;
    end

    // Next-state for all pipeline registers; a taken branch overrides a stall.
    always_comb begin
        pc_d          = pc_q + PC_W'(4);
        ifid_instr_d  = imem_rdata;
        ifid_pc_d     = pc_q;
        ifid_valid_d  = 1'b1;
        idex_cls_d    = id_cls;
        idex_rd_d     = id_rd;
        idex_rs1_d    = id_rs1;
        idex_rs2_d    = id_rs2;
        idex_rs1v_d   = id_rs1v;
        idex_rs2v_d   = id_rs2v;
        idex_imm_d    = id_imm;
        idex_pc_d     = ifid_pc_q;
        idex_valid_d  = ifid_valid_q;
        exmem_cls_d   = idex_cls_q;
        exmem_rd_d    = idex_rd_q;
        exmem_alu_d   = ex_alu;
        exmem_sdata_d = ex_opb;
        exmem_valid_d = idex_valid_q;
        memwb_rd_d    = exmem_rd_q;
        memwb_data_d  = (exmem_rd_q != 5'd0) ? mem_result : '0;
        memwb_valid_d = exmem_valid_q;
        if (ex_taken || hz_stall) begin
            idex_cls_d   = CLS_NOP;
            idex_rd_d    = 5'd0;
            idex_rs1_d   = 5'd0;
            idex_rs2_d   = 5'd0;
            idex_valid_d = 1'b0;
        end
        if (ex_taken) begin
            pc_d         = idex_pc_q + idex_imm_q[PC_W-1:0];
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (hz_stall) begin
            pc_d         = pc_q;
            ifid_instr_d = ifid_instr_q;
            ifid_pc_d    = ifid_pc_q;
            ifid_valid_d = ifid_valid_q;
        end
    end

    // Pipeline and register-file state with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q          <= '0;
            ifid_instr_q  <= NOP_INSTR;
            ifid_pc_q     <= '0;
            ifid_valid_q  <= 1'b0;
            idex_cls_q    <= CLS_NOP;
            idex_rd_q     <= 5'd0;
            idex_rs1_q    <= 5'd0;
            idex_rs2_q    <= 5'd0;
            idex_rs1v_q   <= '0;
            idex_rs2v_q   <= '0;
            idex_imm_q    <= '0;
            idex_pc_q     <= '0;
            idex_valid_q  <= 1'b0;
            exmem_cls_q   <= CLS_NOP;
            exmem_rd_q    <= 5'd0;
            exmem_alu_q   <= '0;
            exmem_sdata_q <= '0;
            exmem_valid_q <= 1'b0;
            memwb_rd_q    <= 5'd0;
            memwb_data_q  <= '0;
            memwb_valid_q <= 1'b0;
            for (int i = 0; i < 32; i++) regs_q[i] <= XLEN'(i);
        end else begin
            pc_q          <= pc_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_valid_q  <= ifid_valid_d;
            idex_cls_q    <= idex_cls_d;
            idex_rd_q     <= idex_rd_d;
            idex_rs1_q    <= idex_rs1_d;
            idex_rs2_q    <= idex_rs2_d;
            idex_rs1v_q   <= idex_rs1v_d;
            idex_rs2v_q   <= idex_rs2v_d;
            idex_imm_q    <= idex_imm_d;
            idex_pc_q     <= idex_pc_d;
            idex_valid_q  <= idex_valid_d;
            exmem_cls_q   <= exmem_cls_d;
            exmem_rd_q    <= exmem_rd_d;
            exmem_alu_q   <= exmem_alu_d;
            exmem_sdata_q <= exmem_sdata_d;
            exmem_valid_q <= exmem_valid_d;
            memwb_rd_q    <= memwb_rd_d;
            memwb_data_q  <= memwb_data_d;
            memwb_valid_q <= memwb_valid_d;
            if (memwb_rd_q != 5'd0) regs_q[memwb_rd_q] <= memwb_data_q;
        end
    end

    // Memory and retire ports; the store strobe is suppressed while reset is held.
    assign imem_addr    = pc_q[PC_W-1:2];
    assign dmem_addr    = exmem_alu_q[BYTE_SH +: DADDR_W];
    assign dmem_we      = (exmem_cls_q == CLS_SD) && !reset;
    assign dmem_wdata   = exmem_sdata_q;
    assign retire_valid = memwb_valid_q;
    assign retire_rd    = memwb_rd_q;
    assign retire_data  = memwb_data_q;
    assign stall        = hz_stall && !ex_taken;
    assign flush        = ex_taken;

    // Byte-offset and high address bits are intentionally dropped.
    assign unused_bits  = ^{pc_q[1:0], exmem_alu_q};

endmodule

// File: tb/tb_riscv_pipe_param.sv
// Directed bench: a bypassing instance and an interlock-only instance run the same programs.
module tb_riscv_pipe_param;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned IADDR_W = 10;
    localparam int unsigned DADDR_W = 10;

    logic clock;
    logic reset;

    logic [31:0]     imem  [1024];
    logic [XLEN-1:0] dmem0 [1024];
    logic [XLEN-1:0] dmem1 [1024];

    logic [IADDR_W-1:0] imem_addr0, imem_addr1;
    logic [31:0]        imem_rdata0, imem_rdata1;
    logic [DADDR_W-1:0] dmem_addr0, dmem_addr1;
    logic               dmem_we0, dmem_we1;
    logic [XLEN-1:0]    dmem_wdata0, dmem_wdata1, dmem_rdata0, dmem_rdata1;
    logic               retire_valid0, retire_valid1;
    logic [4:0]         retire_rd0, retire_rd1;
    logic [XLEN-1:0]    retire_data0, retire_data1;
    logic               stall0, stall1, flush0, flush1;

    assign imem_rdata0 = imem[imem_addr0];
    assign imem_rdata1 = imem[imem_addr1];
    assign dmem_rdata0 = dmem0[dmem_addr0];
    assign dmem_rdata1 = dmem1[dmem_addr1];

    riscv_pipe_param #(.XLEN(XLEN), .FWD_EN(1), .IADDR_W(IADDR_W), .DADDR_W(DADDR_W)) dut (
        .clock(clock), .reset(reset),
        .imem_addr(imem_addr0), .imem_rdata(imem_rdata0),
        .dmem_addr(dmem_addr0), .dmem_we(dmem_we0), .dmem_wdata(dmem_wdata0), .dmem_rdata(dmem_rdata0),
        .retire_valid(retire_valid0), .retire_rd(retire_rd0), .retire_data(retire_data0),
        .stall(stall0), .flush(flush0)
    );

    riscv_pipe_param #(.XLEN(XLEN), .FWD_EN(0), .IADDR_W(IADDR_W), .DADDR_W(DADDR_W)) dut_nf (
        .clock(clock), .reset(reset),
        .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
        .dmem_addr(dmem_addr1), .dmem_we(dmem_we1), .dmem_wdata(dmem_wdata1), .dmem_rdata(dmem_rdata1),
        .retire_valid(retire_valid1), .retire_rd(retire_rd1), .retire_data(retire_data1),
        .stall(stall1), .flush(flush1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bench-side data memories.
    always @(posedge clock) begin
        if (dmem_we0) dmem0[dmem_addr0] = dmem_wdata0;
        if (dmem_we1) dmem1[dmem_addr1] = dmem_wdata1;
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    logic [XLEN-1:0] rv0 [32], rv1 [32];
    int              rc0 [32], rc1 [32];
    bit              rs0 [32], rs1 [32];
    int stall_cnt0, stall_cnt1, flush_cnt0, flush_cnt1, we_cnt0, we_cnt1;
    logic [DADDR_W-1:0] we_addr0, we_addr1;
    logic [XLEN-1:0]    we_data0, we_data1;

    // Retire / stall / flush / store log, cycle 0 = first cycle after reset release.
    always @(negedge clock) begin
        if (!reset) begin
            if (retire_valid0) begin rv0[retire_rd0] = retire_data0; rc0[retire_rd0] = cyc; rs0[retire_rd0] = 1'b1; end
            if (retire_valid1) begin rv1[retire_rd1] = retire_data1; rc1[retire_rd1] = cyc; rs1[retire_rd1] = 1'b1; end
            stall_cnt0 += int'(stall0);
            stall_cnt1 += int'(stall1);
            flush_cnt0 += int'(flush0);
            flush_cnt1 += int'(flush1);
            cyc++;
        end
        if (dmem_we0) begin we_cnt0++; we_addr0 = dmem_addr0; we_data0 = dmem_wdata0; end
        if (dmem_we1) begin we_cnt1++; we_addr1 = dmem_addr1; we_data1 = dmem_wdata1; end
    end

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_ld(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b011, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] enc_sd(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic clear_logs();
        cyc = 0;
        stall_cnt0 = 0; stall_cnt1 = 0; flush_cnt0 = 0; flush_cnt1 = 0; we_cnt0 = 0; we_cnt1 = 0;
        we_addr0 = '0; we_addr1 = '0; we_data0 = '0; we_data1 = '0;
        for (int i = 0; i < 32; i++) begin
            rv0[i] = '0; rv1[i] = '0; rc0[i] = -1; rc1[i] = -1; rs0[i] = 1'b0; rs1[i] = 1'b0;
        end
    endtask

    // Put both cores in reset and blank the memories.
    task automatic begin_prog();
        @(posedge clock); #1;
        reset = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            imem[i] = 32'h0000_0013; dmem0[i] = '0; dmem1[i] = '0;
        end
    endtask

    // Release reset and run n cycles.
    task automatic go(input int n);
        @(posedge clock); @(posedge clock); #1;
        clear_logs();
        reset = 1'b0;
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        begin_prog();
        @(posedge clock); @(posedge clock);
        @(negedge clock);
        n_vec++; if (imem_addr0 !== 10'd0) begin n_err++; $display("FAIL rst_imem_addr0: got %0d expected 0", imem_addr0); end
        n_vec++; if (imem_addr1 !== 10'd0) begin n_err++; $display("FAIL rst_imem_addr1: got %0d expected 0", imem_addr1); end
        n_vec++; if (retire_valid0 !== 1'b0) begin n_err++; $display("FAIL rst_retire_valid0: got %b expected 0", retire_valid0); end
        n_vec++; if (retire_valid1 !== 1'b0) begin n_err++; $display("FAIL rst_retire_valid1: got %b expected 0", retire_valid1); end
        n_vec++; if (stall0 !== 1'b0 || stall1 !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b/%b expected 0/0", stall0, stall1); end
        n_vec++; if (flush0 !== 1'b0 || flush1 !== 1'b0) begin n_err++; $display("FAIL rst_flush: got %b/%b expected 0/0", flush0, flush1); end
        n_vec++; if (dmem_we0 !== 1'b0 || dmem_we1 !== 1'b0) begin n_err++; $display("FAIL rst_dmem_we: got %b/%b expected 0/0", dmem_we0, dmem_we1); end
    endtask

    // ADD x3,x1,x2 ; ADD x4,x3,x3 with x1=1, x2=2 out of reset.
    task automatic test_alu_fwd();
        begin_prog();
        imem[0] = enc_add(5'd3, 5'd1, 5'd2);
        imem[1] = enc_add(5'd4, 5'd3, 5'd3);
        go(16);
        n_vec++; if (rv0[4] !== 64'd6) begin n_err++; $display("FAIL fwd_x4: got %0d expected 6", rv0[4]); end
        n_vec++; if (stall_cnt0 != 0) begin n_err++; $display("FAIL fwd_stalls: got %0d expected 0", stall_cnt0); end
        n_vec++; if (rc0[4] != 5) begin n_err++; $display("FAIL fwd_x4_cycle: got %0d expected 5", rc0[4]); end
        n_vec++; if (rv1[4] !== 64'd6) begin n_err++; $display("FAIL nofwd_x4: got %0d expected 6", rv1[4]); end
        n_vec++; if (stall_cnt1 != 3) begin n_err++; $display("FAIL nofwd_stalls: got %0d expected 3", stall_cnt1); end
        n_vec++; if (rc1[4] != 8) begin n_err++; $display("FAIL nofwd_x4_cycle: got %0d expected 8", rc1[4]); end
    endtask

    // LD x1,0(x0) with DMem[0]=7 ; ADD x2,x1,x1.
    task automatic test_load_use();
        begin_prog();
        imem[0] = enc_ld(5'd1, 5'd0, 12'd0);
        imem[1] = enc_add(5'd2, 5'd1, 5'd1);
        dmem0[0] = 64'd7; dmem1[0] = 64'd7;
        go(16);
        n_vec++; if (rv0[1] !== 64'd7) begin n_err++; $display("FAIL ld_x1: got %0d expected 7", rv0[1]); end
        n_vec++; if (rv0[2] !== 64'd14) begin n_err++; $display("FAIL ld_use_x2: got %0d expected 14", rv0[2]); end
        n_vec++; if (stall_cnt0 != 1) begin n_err++; $display("FAIL ld_use_stalls: got %0d expected 1", stall_cnt0); end
        n_vec++; if (rc0[2] != 6) begin n_err++; $display("FAIL ld_use_cycle: got %0d expected 6", rc0[2]); end
        n_vec++; if (rv1[2] !== 64'd14) begin n_err++; $display("FAIL ld_use_x2_nofwd: got %0d expected 14", rv1[2]); end
        n_vec++; if (stall_cnt1 != 3) begin n_err++; $display("FAIL ld_use_stalls_nofwd: got %0d expected 3", stall_cnt1); end
    endtask

    // BEQ x0,x0,+8 ; ADDI x5,x0,99 (squashed) ; ADDI x6,x0,42 (target).
    task automatic test_branch_taken();
        begin_prog();
        imem[0] = enc_beq(5'd0, 5'd0, 13'd8);
        imem[1] = enc_addi(5'd5, 5'd0, 12'd99);
        imem[2] = enc_addi(5'd6, 5'd0, 12'd42);
        go(16);
        n_vec++; if (flush_cnt0 != 1) begin n_err++; $display("FAIL br_flush: got %0d expected 1", flush_cnt0); end
        n_vec++; if (rs0[5] !== 1'b0) begin n_err++; $display("FAIL br_shadow_retired: got %b expected 0", rs0[5]); end
        n_vec++; if (rv0[6] !== 64'd42) begin n_err++; $display("FAIL br_target_x6: got %0d expected 42", rv0[6]); end
        n_vec++; if (rc0[6] != 7) begin n_err++; $display("FAIL br_target_cycle: got %0d expected 7", rc0[6]); end
        n_vec++; if (flush_cnt1 != 1 || rs1[5] !== 1'b0) begin n_err++; $display("FAIL br_nofwd: got flush %0d shadow %b expected 1 0", flush_cnt1, rs1[5]); end
    endtask

    // BEQ x1,x2,+8 with x1!=x2 falls through at full rate.
    task automatic test_branch_not_taken();
        begin_prog();
        imem[0] = enc_beq(5'd1, 5'd2, 13'd8);
        imem[1] = enc_addi(5'd5, 5'd0, 12'd99);
        imem[2] = enc_addi(5'd6, 5'd0, 12'd42);
        go(16);
        n_vec++; if (flush_cnt0 != 0 || stall_cnt0 != 0) begin n_err++; $display("FAIL bnt_bubbles: got flush %0d stall %0d expected 0 0", flush_cnt0, stall_cnt0); end
        n_vec++; if (rv0[5] !== 64'd99) begin n_err++; $display("FAIL bnt_x5: got %0d expected 99", rv0[5]); end
        n_vec++; if (rc0[6] != 6) begin n_err++; $display("FAIL bnt_x6_cycle: got %0d expected 6", rc0[6]); end
    endtask

    // LD x1,0(x0) with DMem[0]=64 ; SD x30,0(x1) -> store to word 8.
    task automatic test_store_addr_use();
        begin_prog();
        imem[0] = enc_ld(5'd1, 5'd0, 12'd0);
        imem[1] = enc_sd(5'd30, 5'd1, 12'd0);
        dmem0[0] = 64'd64; dmem1[0] = 64'd64;
        go(16);
        n_vec++; if (stall_cnt0 != 1) begin n_err++; $display("FAIL sd_stalls: got %0d expected 1", stall_cnt0); end
        n_vec++; if (we_cnt0 != 1) begin n_err++; $display("FAIL sd_we_count: got %0d expected 1", we_cnt0); end
        n_vec++; if (we_addr0 !== 10'd8) begin n_err++; $display("FAIL sd_addr: got %0d expected 8", we_addr0); end
        n_vec++; if (we_data0 !== 64'd30) begin n_err++; $display("FAIL sd_wdata: got %0d expected 30", we_data0); end
        n_vec++; if (dmem0[8] !== 64'd30) begin n_err++; $display("FAIL sd_mem8: got %0d expected 30", dmem0[8]); end
        n_vec++; if (we_cnt1 != 1 || we_addr1 !== 10'd8 || we_data1 !== 64'd30) begin n_err++; $display("FAIL sd_nofwd: got cnt %0d addr %0d data %0d expected 1 8 30", we_cnt1, we_addr1, we_data1); end
    endtask

    // Negative immediate, wrap, x0 handling and EX/MEM-over-MEM/WB bypass priority.
    task automatic test_imm_x0_priority();
        begin_prog();
        imem[0] = enc_addi(5'd8, 5'd0, 12'hFFF);
        imem[1] = enc_addi(5'd9, 5'd8, 12'd2);
        imem[2] = enc_addi(5'd0, 5'd1, 12'd5);
        imem[3] = enc_add(5'd7, 5'd0, 5'd0);
        imem[4] = enc_addi(5'd10, 5'd0, 12'd1);
        imem[5] = enc_addi(5'd10, 5'd0, 12'd2);
        imem[6] = enc_add(5'd11, 5'd10, 5'd10);
        go(30);
        n_vec++; if (rv0[8] !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL imm_neg_x8: got %0h expected ffffffffffffffff", rv0[8]); end
        n_vec++; if (rv0[9] !== 64'd1) begin n_err++; $display("FAIL imm_wrap_x9: got %0h expected 1", rv0[9]); end
        n_vec++; if (rv0[7] !== 64'd0) begin n_err++; $display("FAIL x0_no_bypass_x7: got %0d expected 0", rv0[7]); end
        n_vec++; if (rv0[11] !== 64'd4) begin n_err++; $display("FAIL fwd_priority_x11: got %0d expected 4", rv0[11]); end
        n_vec++; if (rv1[9] !== 64'd1 || rv1[7] !== 64'd0 || rv1[11] !== 64'd4) begin n_err++; $display("FAIL nofwd_imm_x0: got x9 %0d x7 %0d x11 %0d expected 1 0 4", rv1[9], rv1[7], rv1[11]); end
    endtask

    // Reset while SD x30,0(x0) sits in EX: the store must never reach memory.
    task automatic test_reset_midflight();
        begin_prog();
        imem[0] = enc_sd(5'd30, 5'd0, 12'd0);
        dmem0[0] = 64'd5; dmem1[0] = 64'd5;
        @(posedge clock); @(posedge clock); #1;
        clear_logs();
        reset = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        n_vec++; if (imem_addr0 !== 10'd0 || imem_addr1 !== 10'd0) begin n_err++; $display("FAIL midrst_pc: got %0d/%0d expected 0/0", imem_addr0, imem_addr1); end
        imem[0] = 32'h0000_0013;
        @(negedge clock);
        n_vec++; if (dmem_we0 !== 1'b0 || dmem_we1 !== 1'b0) begin n_err++; $display("FAIL midrst_we: got %b/%b expected 0/0", dmem_we0, dmem_we1); end
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        n_vec++; if (imem_addr0 !== 10'd0) begin n_err++; $display("FAIL midrst_first_fetch: got %0d expected 0", imem_addr0); end
        repeat (10) @(negedge clock);
        #1;
        n_vec++; if (we_cnt0 != 0 || we_cnt1 != 0) begin n_err++; $display("FAIL midrst_we_count: got %0d/%0d expected 0/0", we_cnt0, we_cnt1); end
        n_vec++; if (dmem0[0] !== 64'd5) begin n_err++; $display("FAIL midrst_mem0: got %0d expected 5", dmem0[0]); end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_branch_taken();
        test_branch_not_taken();
        test_store_addr_use();
        test_imm_x0_priority();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_pipe_param.md
RISCV_PIPE_PARAM -- requirements
Module: riscv_pipe_param

Interface
REQ-001 SHALL have parameter XLEN, default 64: register and datapath width, 32 or 64.
REQ-002 SHALL have parameter FWD_EN, default 1: 1 = full bypassing, 0 = interlock-only (no bypass paths).
REQ-003 SHALL have parameter IADDR_W, default 10: instruction word-address width.
REQ-004 SHALL have parameter DADDR_W, default 10: data word-address width.
REQ-005 SHALL have port clock, input, 1: single clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port imem_addr, output, IADDR_W: fetch word address, PC>>2.
REQ-008 SHALL have port imem_rdata, input, 32: instruction; combinational read, same cycle.
REQ-009 SHALL have port dmem_addr, output, DADDR_W: data word address, ALU result >> log2(XLEN/8).
REQ-010 SHALL have port dmem_we, output, 1: store strobe.
REQ-011 SHALL have port dmem_wdata, output, XLEN: store data.
REQ-012 SHALL have port dmem_rdata, input, XLEN: load data; combinational, same cycle.
REQ-013 SHALL have port retire_valid, output, 1: a non-bubble instruction is in WB this cycle.
REQ-014 SHALL have port retire_rd, output, 5: rd of the retiring instruction; 0 when it has none.
REQ-015 SHALL have port retire_data, output, XLEN: value written to rd.
REQ-016 SHALL have port stall, output, 1: IF/ID frozen this cycle.
REQ-017 SHALL have port flush, output, 1: taken-branch squash this cycle.

Function
REQ-018 SHALL implement a 5-stage pipeline (IF, ID, EX, MEM, WB) with one instruction per cycle.
REQ-019 SHALL decode the following instructions:
- LD: opcode 0000011, funct3 = 011 for XLEN 64, 010 for XLEN 32.
- SD: opcode 0100011, same funct3 rule.
- ADDI: opcode 0010011, funct3 000.
- ADD: opcode 0110011, funct7 0.
- BEQ: opcode 1100011, funct3 000.
- Every other encoding SHALL behave as NOP (0x00000013).
REQ-020 SHALL sign-extend immediates to XLEN and wrap all sums modulo 2^XLEN.
REQ-021 SHALL hardwire x0 to 0: writes to x0 are discarded and reads of x0 are never bypassed.
REQ-022 SHALL make a WB write visible to an ID read in the same cycle (write-through register file).
REQ-023 With FWD_EN=1, SHALL bypass into EX from EX/MEM (ALU results) and from MEM/WB (ALU or load results), with EX/MEM taking priority.
REQ-024 With FWD_EN=1, SHALL stall exactly 1 cycle when ID/EX holds an LD and an instruction in ID reads its rd (rs1 always; rs2 for ADD, SD, BEQ).
REQ-025 With FWD_EN=0, SHALL stall in ID while any instruction in ID/EX, EX/MEM or MEM/WB writes a nonzero register that the ID instruction reads.
REQ-026 On a stall, SHALL hold PC and IF/ID and insert a NOP into ID/EX; the later stages SHALL advance.
REQ-027 SHALL resolve BEQ in EX: if taken, PC <= branch PC + imm, IF/ID and ID/EX become NOP, and flush is high for 1 cycle (2-cycle penalty).
REQ-028 When a stall and a taken-branch flush coincide, flush SHALL win.
REQ-029 SHALL treat a not-taken BEQ with zero penalty (static predict not-taken).
REQ-030 SHALL assert dmem_we only while an SD is in MEM.
REQ-031 SHALL wrap PC modulo 2^(IADDR_W+2).

Reset
REQ-032 While reset is high at a clock edge, SHALL set:
- PC = 0;
- all pipeline instruction registers = NOP;
- Regs[i] = i;
- dmem_we, retire_valid, stall, flush = 0.
REQ-033 A reset asserted mid-flight SHALL discard in-flight instructions with no dmem write in that cycle.
REQ-034 After reset deasserts, the first fetch SHALL be from address 0.

Structure
REQ-035 SHALL place opcode, funct3 and NOP constants and an instruction-class enum in package riscv_pipe_pkg.
REQ-036 SHALL implement hazard detection and bypass selection in one sub-module, riscv_hazard_unit; the datapath stays in the top.

Verification
REQ-037 SHALL cover ADD x3,x1,x2 followed immediately by ADD x4,x3,x3 with FWD_EN=1 -> no stall; x4 = 6.
REQ-038 SHALL cover LD x1,0(x0) (DMem[0]=7) followed by ADD x2,x1,x1 -> stall high for exactly 1 cycle; x2 = 14.
REQ-039 SHALL cover the REQ-037 program with FWD_EN=0 -> stall high for 3 cycles; x4 = 6.
REQ-040 SHALL cover a taken BEQ x0,x0,+8 -> flush for 1 cycle; the instruction at +4 never retires; the target retires.
REQ-041 SHALL cover LD x1 then SD x30,0(x1) (address-use) -> 1 stall; dmem_we with dmem_addr = the loaded value >> 3.
REQ-042 SHALL cover reset asserted while an SD is in EX -> no dmem_we; PC = 0 on the next cycle.
